// File: rtl/run_launcher_pkg.sv
// Shared types and default widths for the run launcher.
//   state_e    : launcher FSM states
//   CYC_W_DEF  : default cycle counter / resp_cycles width
//   PROG_W_DEF : default program select width
package run_launcher_pkg;

  localparam int unsigned CYC_W_DEF  = 16;
  localparam int unsigned PROG_W_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RUN,
    REPORT
  } state_e;

endpackage

// File: rtl/run_launcher_if.sv
// Host-side request/response handshake of the run launcher.
//   req_valid/req_ready/req_prog           : run request (host -> launcher)
//   resp_valid/resp_ready/resp_cycles/
//   resp_timeout                           : run result (launcher -> host)
// master = host / bench, slave = launcher.
interface run_launcher_if
  import run_launcher_pkg::*;
#(
  parameter int unsigned CYC_W  = CYC_W_DEF,
  parameter int unsigned PROG_W = PROG_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic [PROG_W-1:0] req_prog;
  logic              resp_valid;
  logic              resp_ready;
  logic [CYC_W-1:0]  resp_cycles;
  logic              resp_timeout;

  modport master (
    output req_valid, req_prog, resp_ready,
    input  req_ready, resp_valid, resp_cycles, resp_timeout
  );

  modport slave (
    input  req_valid, req_prog, resp_ready,
    output req_ready, resp_valid, resp_cycles, resp_timeout
  );

endinterface

// File: rtl/run_launcher.sv
// Initiator side of the controller run/done handshake.
// Accepts a run request, holds the controller in reset for RST_CYCLES
// cycles, releases it, counts cycles until core_done or TIMEOUT, and
// reports the run length on a valid/ready response.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   host        : run_launcher_if.slave request/response handshake
//   core_reset  : active-high reset to the controller
//   core_prog   : latched program select to the controller
//   core_done   : controller done level
//   stat_runs, stat_timeouts : saturating run statistics, present only
//                 when RUN_LAUNCHER_STATS_EN is defined
// All outputs are registered.
module run_launcher
  import run_launcher_pkg::*;
#(
  parameter int unsigned CYC_W      = CYC_W_DEF,
  parameter int unsigned PROG_W     = PROG_W_DEF,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic              clk,
  input  logic              reset,
  run_launcher_if.slave     host,
  output logic              core_reset,
  output logic [PROG_W-1:0] core_prog,
  input  logic              core_done
`ifdef RUN_LAUNCHER_STATS_EN
  ,
  output logic [CYC_W-1:0]  stat_runs,
  output logic [CYC_W-1:0]  stat_timeouts
`endif
);

  localparam logic [CYC_W-1:0] CNT_ONE   = CYC_W'(1);
  localparam logic [CYC_W-1:0] HOLD_LAST = CYC_W'(RST_CYCLES - 1);
  localparam logic [CYC_W-1:0] TIMEOUT_C = CYC_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [CYC_W-1:0]  cnt_q, cnt_d;
  logic [PROG_W-1:0] prog_d;
  logic [CYC_W-1:0]  resp_cycles_d;
  logic              resp_timeout_d;
  logic              req_ready_d;
  logic              core_reset_d;
  logic              resp_valid_d;

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      core_prog         <= '0;
      core_reset        <= 1'b1;
      host.req_ready    <= 1'b0;
      host.resp_valid   <= 1'b0;
      host.resp_cycles  <= '0;
      host.resp_timeout <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      core_prog         <= prog_d;
      core_reset        <= core_reset_d;
      host.req_ready    <= req_ready_d;
      host.resp_valid   <= resp_valid_d;
      host.resp_cycles  <= resp_cycles_d;
      host.resp_timeout <= resp_timeout_d;
    end
  end

  // Next state, counter and output values
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    prog_d         = core_prog;
    resp_cycles_d  = host.resp_cycles;
    resp_timeout_d = host.resp_timeout;

    case (state_q)
      IDLE: begin
        // req_ready is low in the first cycle after reset release
        if (host.req_valid && host.req_ready) begin
          prog_d  = host.req_prog;
          cnt_d   = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // cnt counts hold cycles; core_done is ignored here
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = CNT_ONE;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RUN: begin
        // done takes priority over a coincident timeout
        if (core_done) begin
          resp_cycles_d  = cnt_q;
          resp_timeout_d = 1'b0;
          state_d        = REPORT;
        end else if (cnt_q == TIMEOUT_C) begin
          resp_cycles_d  = TIMEOUT_C;
          resp_timeout_d = 1'b1;
          state_d        = REPORT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      REPORT: begin
        if (host.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they align with it
    req_ready_d  = (state_d == IDLE);
    core_reset_d = (state_d != RUN);
    resp_valid_d = (state_d == REPORT);
  end

`ifdef RUN_LAUNCHER_STATS_EN
  logic resp_hs;

  assign resp_hs = (state_q == REPORT) && host.resp_ready;

  // Saturating run / timeout counters, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_runs     <= '0;
      stat_timeouts <= '0;
    end else if (resp_hs) begin
      if (stat_runs != '1) begin
        stat_runs <= stat_runs + CNT_ONE;
      end
      if (host.resp_timeout && (stat_timeouts != '1)) begin
        stat_timeouts <= stat_timeouts + CNT_ONE;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_run_launcher.sv
// Self-checking bench for run_launcher: directed scenarios plus randomized
// runs, checked against a run-level model (expected length = done cycle or
// TIMEOUT, whichever first, done winning ties).
module tb_run_launcher;

  localparam int unsigned CYC_W      = 16;
  localparam int unsigned PROG_W     = 2;
  localparam int unsigned RST_CYCLES = 2;
  localparam int unsigned TIMEOUT    = 1000;

  logic              clk;
  logic              reset;
  logic              core_reset;
  logic [PROG_W-1:0] core_prog;
  logic              core_done;
`ifdef RUN_LAUNCHER_STATS_EN
  logic [CYC_W-1:0]  stat_runs;
  logic [CYC_W-1:0]  stat_timeouts;
`endif

  int checks;
  int errors;
  int exp_runs;
  int exp_tos;

  run_launcher_if #(.CYC_W(CYC_W), .PROG_W(PROG_W)) bus ();

  run_launcher #(
    .CYC_W(CYC_W), .PROG_W(PROG_W), .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .host(bus.slave),
    .core_reset(core_reset),
    .core_prog(core_prog),
    .core_done(core_done)
`ifdef RUN_LAUNCHER_STATS_EN
    ,
    .stat_runs(stat_runs),
    .stat_timeouts(stat_timeouts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    chk({tag, "_core_prog"}, 32'(core_prog), 32'd0);
    chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, "_resp_cycles"}, 32'(bus.resp_cycles), 32'd0);
    chk({tag, "_resp_timeout"}, 32'(bus.resp_timeout), 32'd0);
  endtask

  task automatic chk_stats();
`ifdef RUN_LAUNCHER_STATS_EN
    chk("stat_runs", 32'(stat_runs), 32'(exp_runs));
    chk("stat_timeouts", 32'(stat_timeouts), 32'(exp_tos));
`endif
  endtask

  // One complete run. done_at = RUN cycle at which done rises (0 = never);
  // hold_done = level of core_done throughout HOLD; stall = cycles resp_ready low.
  task automatic do_run(input logic [PROG_W-1:0] prog, input int done_at,
                        input bit hold_done, input int stall);
    int hold_n;
    int run_n;
    int exp_cyc;
    bit exp_to_b;
    exp_to_b = (done_at == 0) || (done_at > int'(TIMEOUT));
    exp_cyc  = exp_to_b ? int'(TIMEOUT) : done_at;

    chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_prog  = prog;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_prog  = PROG_W'($urandom);

    hold_n = 0;
    while (core_reset && hold_n < int'(RST_CYCLES) + 8) begin
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
      chk("hold_core_prog", 32'(core_prog), 32'(prog));
      core_done = hold_done;
      hold_n++;
      @(negedge clk);
    end
    chk("hold_cycles", 32'(hold_n), 32'(RST_CYCLES));

    run_n = 0;
    while (!core_reset && run_n < int'(TIMEOUT) + 8) begin
      run_n++;
      core_done = (done_at != 0) && (run_n >= done_at);
      @(negedge clk);
    end
    core_done = 1'b0;
    chk("run_cycles", 32'(run_n), 32'(exp_cyc));
    chk("report_valid", 32'(bus.resp_valid), 32'd1);
    chk("report_cycles", 32'(bus.resp_cycles), 32'(exp_cyc));
    chk("report_timeout", 32'(bus.resp_timeout), 32'(exp_to_b));
    chk("report_core_reset", 32'(core_reset), 32'd1);
    chk("report_core_prog", 32'(core_prog), 32'(prog));

    for (int s = 0; s < stall; s++) begin
      bus.resp_ready = 1'b0;
      bus.req_valid  = 1'b1;
      bus.req_prog   = PROG_W'($urandom);
      @(negedge clk);
      chk("stall_valid", 32'(bus.resp_valid), 32'd1);
      chk("stall_cycles", 32'(bus.resp_cycles), 32'(exp_cyc));
      chk("stall_timeout", 32'(bus.resp_timeout), 32'(exp_to_b));
      chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
    end

    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b0;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk("post_hs_valid", 32'(bus.resp_valid), 32'd0);
    chk("post_hs_req_ready", 32'(bus.req_ready), 32'd1);
    chk("post_hs_core_reset", 32'(core_reset), 32'd1);

    if (exp_runs < 65535) exp_runs++;
    if (exp_to_b && exp_tos < 65535) exp_tos++;
    chk_stats();
  endtask

  initial begin
    int run_n;
    int seen_valid;
    checks         = 0;
    errors         = 0;
    exp_runs       = 0;
    exp_tos        = 0;
    reset          = 1'b0;
    core_done      = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_prog   = '0;
    bus.resp_ready = 1'b0;

    // Reset held for 3 cycles
    repeat (3) @(negedge clk);
    chk_reset_values("rst");
    chk_stats();
    reset = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rel_core_reset", 32'(core_reset), 32'd1);
    chk("rel_resp_valid", 32'(bus.resp_valid), 32'd0);

    // Done on 5th RUN cycle, then a timeout run with a 4-cycle response stall
    do_run(2'b10, 5, 1'b0, 0);
    do_run(2'b01, 0, 1'b0, 4);
`ifdef RUN_LAUNCHER_STATS_EN
    chk("stats_two_runs", 32'(stat_runs), 32'd2);
    chk("stats_one_timeout", 32'(stat_timeouts), 32'd1);
`endif

    // Done level during HOLD is ignored; later done, then timeout
    do_run(2'b11, 20, 1'b1, 1);
    do_run(2'b00, 0, 1'b1, 0);
    // Done stuck high from before the run
    do_run(2'b01, 1, 1'b1, 2);
    // Done exactly at TIMEOUT wins; one cycle later is a timeout
    do_run(2'b10, int'(TIMEOUT), 1'b0, 0);
    do_run(2'b11, int'(TIMEOUT) + 1, 1'b0, 0);

    // Randomized short runs
    for (int i = 0; i < 12; i++) begin
      do_run(PROG_W'($urandom), int'($urandom_range(1, 40)),
             1'($urandom), int'($urandom_range(0, 4)));
    end

    // Reset asserted mid-RUN at count 37
    bus.req_valid = 1'b1;
    bus.req_prog  = 2'b11;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (RST_CYCLES) @(negedge clk);
    run_n = 0;
    while (!core_reset && run_n < 37) begin
      run_n++;
      if (run_n < 37) @(negedge clk);
    end
    chk("midrun_count", 32'(run_n), 32'd37);
    reset = 1'b0;
    #1;
    chk_reset_values("midrun");
    exp_runs = 0;
    exp_tos  = 0;
    chk_stats();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    seen_valid = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.resp_valid) seen_valid++;
    end
    chk("midrun_no_resp", 32'(seen_valid), 32'd0);
    chk("midrun_req_ready", 32'(bus.req_ready), 32'd1);

    // Normal operation after mid-run reset
    do_run(2'b01, 9, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_launcher.md
Name: run_launcher

Overview:
- Initiator side of the controller's run/`done` handshake.
- Accepts a run request from the host or test harness, latches a program select, and holds the controller in reset for a fixed number of cycles.
- Releases reset, counts cycles until the controller raises `done` or a timeout expires, then presents the result on a valid/ready response port.
- Sits between the host/bench and the controller; it replaces free-running benches that never see `done`.

Parameters:
- CYC_W, 16: width of the cycle counter and of `resp_cycles`.
- PROG_W, 2: width of the program select.
- RST_CYCLES, 2: number of cycles `core_reset` is held high per run; legal range is 1 or more.
- TIMEOUT, 1000: run-cycle limit; must be less than 2^CYC_W.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (reset is asserted when 0).
- req_valid  in  1  host run request.
- req_ready  out  1  launcher can accept a request.
- req_prog  in  PROG_W  program select for the run.
- core_reset  out  1  active-high reset to the controller.
- core_prog  out  PROG_W  latched program select to the controller.
- core_done  in  1  controller `done` level.
- resp_valid  out  1  result available.
- resp_ready  in  1  host accepts result.
- resp_cycles  out  CYC_W  run length in cycles.
- resp_timeout  out  1  run ended by timeout, not `done`.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - req_ready=0, core_reset=1 (controller held in reset), core_prog=0, resp_valid=0, resp_cycles=0, resp_timeout=0, counters=0.
- First edge after reset release: IDLE with req_ready=1.
- IDLE:
  - req_ready=1, core_reset=1.
  - On req_valid&&req_ready: latch core_prog<=req_prog, clear the counter, go to HOLD.
- HOLD:
  - core_reset=1 for exactly RST_CYCLES cycles, counted from the cycle after acceptance; then go to RUN.
  - core_done is ignored in HOLD.
- RUN:
  - core_reset=0; the counter increments every cycle.
  - The first RUN cycle samples count=1.
  - If core_done=1: resp_cycles<=count, resp_timeout<=0, go to REPORT.
  - Otherwise, if count==TIMEOUT: resp_cycles<=TIMEOUT, resp_timeout<=1, go to REPORT.
  - If core_done=1 and count==TIMEOUT in the same cycle, done wins and resp_timeout=0.
- REPORT:
  - resp_valid=1; core_reset=1 (controller re-held); core_prog still held.
  - resp_cycles and resp_timeout are stable while resp_valid=1 && !resp_ready.
  - On resp_ready: resp_valid<=0, go to IDLE. The next request can be accepted at the earliest one cycle later.
- req_ready=0 in HOLD, RUN and REPORT. req_valid is ignored there and never queued.
- All outputs are registered; there are no combinational input-to-output paths.
- Latency: from acceptance to first core_reset=0 cycle is RST_CYCLES+1 edges. From core_done sampled high to resp_valid=1 is 1 edge.
- core_done stuck high: a run started with done already high completes with resp_cycles=1.
- Reset mid-run: immediate return to the reset values; the in-flight result is discarded, with no resp_valid.

Optional Feature:
- Macro: RUN_LAUNCHER_STATS_EN.
- Defined: adds outputs stat_runs (CYC_W) and stat_timeouts (CYC_W).
  - stat_runs increments on every REPORT handshake.
  - stat_timeouts increments on every REPORT handshake with resp_timeout=1.
  - Both saturate at all-ones and clear only on reset.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package run_launcher_pkg:
  - state enum {IDLE, HOLD, RUN, REPORT}.
  - default width constants for CYC_W and PROG_W.
- No sub-module: the FSM and counter stay in one module (~150–250 lines).

Test Plan:
1. Reset with reset=0 for 3 cycles, then release -> core_reset=1, resp_valid=0, req_ready=1 on the first edge after release.
2. req_prog=2'b10 accepted; stub raises core_done on the 5th RUN cycle -> core_reset high 2 cycles, core_prog=2 throughout, resp_cycles=5, resp_timeout=0.
3. Stub never raises done -> resp_cycles=1000, resp_timeout=1 exactly 1000 RUN cycles after core_reset falls.
4. core_done pulsed during HOLD, then low -> the pulse is ignored and the run continues to timeout or a later done.
5. resp_ready held low 4 cycles -> resp_valid and resp_cycles stable; req_valid=1 meanwhile is not accepted (req_ready=0).
6. Reset asserted mid-RUN at count=37 -> outputs return to reset values immediately; no resp_valid appears after release.
7. With RUN_LAUNCHER_STATS_EN: run scenarios 2 and 3 back-to-back -> stat_runs=2, stat_timeouts=1.
